// File: rtl/led_scan_sequencer.sv
// rtl/led_scan_sequencer.sv - 74HC595 LED Pmod scan sequencer with 4-level grayscale
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   enable       run scanning; sampled only between words
//   row_rd       one-clk frame-buffer read strobe
//   row_addr     row being read, valid with row_rd
//   row_data     {col7..col0} 2-bit densities, valid 1 clk after row_rd
//   sclk         595 shift clock
//   rclk         595 storage latch
//   srclr_n      595 clear, active low (low only while idle)
//   serial_data  595 serial input, MSB first
//   busy         high whenever not idle
//   frame_done   one-clk pulse after the last word of a frame latches
module led_scan_sequencer #(
    parameter int CLK_DIV = 100,
    parameter int ROWS    = 8,
    parameter int PLANES  = 3,
    localparam int RW     = $clog2(ROWS),
    localparam int CW     = $clog2(CLK_DIV),
    localparam int PW     = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          row_rd,
    output logic [RW-1:0] row_addr,
    input  logic [15:0]   row_data,
    output logic          sclk,
    output logic          rclk,
    output logic          srclr_n,
    output logic          serial_data,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [2:0] {
        IDLE, FETCH, CAPTURE, SHIFT, LATCH, ADVANCE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] div_cnt;
    logic          phase;      // SHIFT: 0 = data setup, 1 = sclk high; LATCH: 0 = rclk high, 1 = rclk low
    logic [3:0]    bit_idx;
    logic [15:0]   word;
    logic [15:0]   cap_word;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic          sd_q;
    logic          tick;
    logic          last_plane;
    logic          last_row;

    assign tick       = (div_cnt == CW'(CLK_DIV - 1));
    assign last_plane = (plane == PW'(PLANES - 1));
    assign last_row   = (row == RW'(ROWS - 1));

    // A column is lit in this plane when its density exceeds the plane index,
    // so density d is lit in planes 0..d-1.
    always_comb begin
        cap_word       = '0;
        cap_word[15:8] = 8'd1 << row;
        for (int i = 0; i < 8; i++) begin
            cap_word[i] = ({30'd0, row_data[2*i +: 2]} > 32'(plane));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        row_rd     = 1'b0;
        sclk       = 1'b0;
        rclk       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (enable) state_next = FETCH;
            FETCH: begin
                row_rd     = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: state_next = SHIFT;
            SHIFT: begin
                sclk = phase;
                if (tick && phase && (bit_idx == 4'd0)) state_next = LATCH;
            end
            LATCH: begin
                rclk = ~phase;
                if (tick && phase) state_next = ADVANCE;
            end
            ADVANCE: begin
                frame_done = last_plane && last_row;
                state_next = enable ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign srclr_n     = (state != IDLE);
    assign row_addr    = row;
    assign serial_data = sd_q;

    // serial_data is registered and only updated when a new phase A begins,
    // so it stays put through the sclk-high half and through LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_idx <= 4'd0;
            word    <= 16'd0;
            row     <= '0;
            plane   <= '0;
            sd_q    <= 1'b0;
        end else begin
            if ((state == SHIFT || state == LATCH) && !tick) div_cnt <= div_cnt + 1'b1;
            else                                              div_cnt <= '0;

            case (state)
                CAPTURE: begin
                    word    <= cap_word;
                    bit_idx <= 4'd15;
                    phase   <= 1'b0;
                    sd_q    <= cap_word[15];
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (bit_idx != 4'd0) begin
                                bit_idx <= bit_idx - 4'd1;
                                sd_q    <= word[bit_idx - 4'd1];
                            end
                        end
                    end
                end
                LATCH: begin
                    if (tick) phase <= ~phase;
                end
                ADVANCE: begin
                    if (last_plane) begin
                        plane <= '0;
                        row   <= last_row ? '0 : row + 1'b1;
                    end else begin
                        plane <= plane + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// tb/tb_led_scan_sequencer.sv - randomized self-checking bench for led_scan_sequencer
module tb_led_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] row_data = 16'd0;
    logic        row_rd, sclk, rclk, srclr_n, serial_data, busy, frame_done;
    logic [2:0]  row_addr;

    led_scan_sequencer #(.CLK_DIV(2), .ROWS(8), .PLANES(3)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .row_rd(row_rd), .row_addr(row_addr), .row_data(row_data),
        .sclk(sclk), .rclk(rclk), .srclr_n(srclr_n), .serial_data(serial_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected 595 contents: row one-hot on top, a column lit when its density exceeds the plane.
    function automatic logic [15:0] model_word(input logic [15:0] d, input int r, input int p);
        logic [15:0] w;
        int dens;
        w = 16'h0;
        w[8 + r] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dens = int'((d >> (2 * i)) & 16'h3);
            if (p < dens) w[i] = 1'b1;
        end
        return w;
    endfunction

    logic [15:0] fb [8];
    logic        mutate_en = 1'b0;
    logic        rd_seen = 1'b0;
    logic [15:0] rd_val = 16'd0;

    // Model of the pins: a 595 shift register plus word-order bookkeeping.
    int          row_m = 0, plane_m = 0;
    logic [15:0] fetched_q [$];
    logic [15:0] log_w [$];
    logic [15:0] sr = 16'd0;
    int          bits = 0;
    int          fd_count = 0;
    int          rd_count = 0;
    int          last_rd_addr = -1;
    bit          fd_pending = 1'b0;
    logic        prev_sclk = 1'b0, prev_rclk = 1'b0, prev_sd = 1'b0;
    int          sd_stable = 0;

    // Synchronous frame-buffer read port; junk on row_data at all other times.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen) row_data = rd_val;
            else         row_data = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        rd_seen = 1'b0;
        if (rst) begin
            row_m = 0; plane_m = 0; fetched_q.delete(); bits = 0;
            fd_pending = 1'b0; fd_count = 0; rd_count = 0;
            prev_sclk = 1'b0; prev_rclk = 1'b0; prev_sd = 1'b0; sd_stable = 0;
        end else begin
            chk("srclr_eq_busy", {31'd0, srclr_n}, {31'd0, busy});
            chk("sclk_rclk_excl", {31'd0, sclk & rclk}, 32'd0);
            if (!busy) chk("idle_quiet", {28'd0, sclk, rclk, row_rd, frame_done}, 32'd0);
            if (row_rd) begin
                chk("row_addr", {29'd0, row_addr}, row_m);
                chk("fetch_between_words", bits, 0);
                if (fd_pending) begin
                    chk("frame_done_missing", 32'd0, 32'd1);
                    fd_pending = 1'b0;
                end
                rd_val = fb[row_addr];
                fetched_q.push_back(rd_val);
                rd_seen = 1'b1;
                rd_count++;
                last_rd_addr = int'(row_addr);
                if (mutate_en) fb[$urandom_range(0, 7)] = 16'($urandom);
            end
            if (sclk && !prev_sclk) begin
                chk("sd_setup", {31'd0, (serial_data === prev_sd) && (sd_stable >= 2)}, 32'd1);
                sr = {sr[14:0], serial_data};
                bits++;
            end
            if (rclk && !prev_rclk) begin
                chk("bits_per_word", bits, 16);
                if (fetched_q.size() == 0) begin
                    chk("latch_without_fetch", 32'd0, 32'd1);
                end else begin
                    chk("latched_word", {16'd0, sr}, {16'd0, model_word(fetched_q.pop_front(), row_m, plane_m)});
                end
                log_w.push_back(sr);
                if (row_m == 7 && plane_m == 2) fd_pending = 1'b1;
                plane_m++;
                if (plane_m == 3) begin
                    plane_m = 0;
                    row_m = (row_m + 1) % 8;
                end
                bits = 0;
            end
            if (frame_done) begin
                chk("frame_done_expected", {31'd0, fd_pending}, 32'd1);
                fd_pending = 1'b0;
                fd_count++;
            end
            if (serial_data === prev_sd) sd_stable++;
            else                         sd_stable = 1;
            prev_sd = serial_data;
            prev_sclk = sclk;
            prev_rclk = rclk;
        end
    end

    int n0, rc0, t;

    initial begin
        for (int i = 0; i < 8; i++) fb[i] = 16'($urandom);
        fb[0] = 16'hFFFF;
        fb[3] = 16'b11_10_01_00_11_10_01_00;

        chk("model_pin_row0", {16'd0, model_word(16'hFFFF, 0, 0)}, 32'h01FF);
        chk("model_pin_row3_p2", {16'd0, model_word(16'b11_10_01_00_11_10_01_00, 3, 2)}, 32'h0888);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {22'd0, row_rd, row_addr, sclk, rclk, srclr_n, serial_data, busy, frame_done}, 32'd0);

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        for (t = 0; t < 500 && bits < 5; t++) @(negedge clk);
        chk("reach_mid_shift", {31'd0, bits >= 5}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {22'd0, row_rd, row_addr, sclk, rclk, srclr_n, serial_data, busy, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);
        chk("no_fetch_while_idle", rd_count, 0);

        // One full frame from row 0
        log_w.delete();
        enable = 1'b1;
        for (t = 0; t < 3000 && log_w.size() < 24; t++) @(negedge clk);
        chk("frame_words", log_w.size(), 24);
        rc0 = rd_count;
        for (t = 0; t < 100 && rd_count == rc0; t++) @(negedge clk);
        chk("fetch_after_frame", {31'd0, rd_count > rc0}, 32'd1);
        chk("frame_done_once", fd_count, 1);
        chk("wrap_row_addr", last_rd_addr, 0);
        chk("first_word", {16'd0, log_w[0]}, 32'h01FF);
        chk("row3_plane0", {16'd0, log_w[9]}, 32'h08EE);
        chk("row3_plane1", {16'd0, log_w[10]}, 32'h08CC);
        chk("row3_plane2", {16'd0, log_w[11]}, 32'h0888);

        // Frame buffer contents change between fetches from here on
        mutate_en = 1'b1;
        n0 = log_w.size();
        for (t = 0; t < 1000 && log_w.size() < n0 + 6; t++) @(negedge clk);

        // Drop enable during bit 7: the word still completes, then idle
        rc0 = rd_count;
        for (t = 0; t < 200 && rd_count == rc0; t++) @(negedge clk);
        for (t = 0; t < 200 && !(bits == 8 && !sclk); t++) @(negedge clk);
        chk("reach_bit7", bits, 8);
        n0 = log_w.size();
        enable = 1'b0;
        for (t = 0; t < 300 && busy; t++) @(negedge clk);
        chk("drop_word_latched", log_w.size(), n0 + 1);
        chk("drop_idle_busy", {31'd0, busy}, 32'd0);
        chk("drop_idle_srclr", {31'd0, srclr_n}, 32'd0);
        rc0 = rd_count;
        repeat (50) @(negedge clk);
        chk("drop_stays_idle", rd_count, rc0);

        // Random enable toggling; the model checks every word and resume point
        for (int c = 0; c < 3000; ) begin
            int d;
            d = int'($urandom_range(1, 120));
            enable = ($urandom_range(0, 3) != 0);
            repeat (d) @(negedge clk);
            c += d;
        end
        enable = 1'b0;
        for (t = 0; t < 300 && busy; t++) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);
        chk("no_pending_frame_done", {31'd0, fd_pending}, 32'd0);
        chk("no_unshifted_fetch", fetched_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
